// File: rtl/loader_ram_writer.sv
// Buffers loader byte writes in a small FIFO and drains them into the shared RAM port
// in free cycles. Drops ROM-region writes and signals load completion / start-address jump.
module loader_ram_writer #(
    parameter int              DATA    = 8,
    parameter int              ADDR    = 16,
    parameter int              DEPTH   = 8,
    parameter logic [ADDR-1:0] ROM_TOP = 16'h3000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            loader_wr,
    input  logic            loader_download,
    input  logic [ADDR-1:0] loader_addr,
    input  logic [DATA-1:0] loader_data,
    input  logic [ADDR-1:0] execute_addr,
    input  logic            execute_enable,
    input  logic            ram_gnt,
    output logic            ram_we,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_data,
    output logic            busy,
    output logic            load_done,
    output logic            exec_go,
    output logic [ADDR-1:0] exec_addr,
    output logic            overflow,
    output logic [15:0]     bytes_written,
    output logic [7:0]      dropped_count,
    output logic [1:0]      state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR-1:0] mem_addr [DEPTH];
    logic [DATA-1:0] mem_data [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic            dl_q;
    logic            exec_pending;

    logic dl_rise, dl_fall;
    logic push_req, prot_drop, full, pop, push, lost, clear_stats;

    // Handshake: ram_we is valid (head entry present), ram_gnt is ready. A write
    // transfers on every edge where both are high; the head is held stable otherwise.
    assign ram_we   = (count != '0);
    assign ram_addr = ram_we ? mem_addr[rd_ptr] : '0;
    assign ram_data = ram_we ? mem_data[rd_ptr] : '0;

    assign dl_rise     = loader_download && !dl_q;
    assign dl_fall     = !loader_download && dl_q;
    assign push_req    = loader_wr && (loader_addr >= ROM_TOP);
    assign prot_drop   = loader_wr && (loader_addr < ROM_TOP);
    assign full        = (count == FULL_CNT);
    assign pop         = ram_we && ram_gnt;
    assign lost        = push_req && full && !pop;
    assign push        = push_req && !lost;
    assign clear_stats = (state_q == S_IDLE) && dl_rise;
    assign state_dbg   = state_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (dl_rise) state_d = S_LOAD;
            S_LOAD:   if (dl_fall) state_d = S_DRAIN;
            S_DRAIN: begin
                if (loader_download)             state_d = S_LOAD;
                else if (count == '0 && !push)   state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        load_done = (state_q == S_FINISH);
        exec_go   = (state_q == S_FINISH) && exec_pending;
    end

    // Storage carries no reset: the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_addr[wr_ptr] <= loader_addr;
            mem_data[wr_ptr] <= loader_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dl_q          <= 1'b0;
            exec_pending  <= 1'b0;
            exec_addr     <= '0;
            overflow      <= 1'b0;
            bytes_written <= '0;
            dropped_count <= '0;
        end else begin
            dl_q <= loader_download;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase

            // A new download restarts the statistics; events of the same cycle still count.
            if (clear_stats) begin
                bytes_written <= pop ? 16'd1 : 16'd0;
                overflow      <= lost;
                dropped_count <= (lost || prot_drop) ? 8'd1 : 8'd0;
            end else begin
                if (pop) bytes_written <= bytes_written + 16'd1;
                if (lost) overflow <= 1'b1;
                if ((lost || prot_drop) && dropped_count != 8'hFF)
                    dropped_count <= dropped_count + 8'd1;
            end

            if (execute_enable) begin
                exec_addr    <= execute_addr;
                exec_pending <= 1'b1;
            end else if (state_q == S_FINISH) begin
                exec_pending <= 1'b0;
            end
        end
    end

endmodule
